// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port RAM among NUM_REQ requesters.
// Each transaction runs ARB -> ACCESS -> RESP, with grant and response as one-cycle pulses.
module sp_ram_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      err,
   output logic                      busy
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {ARB, ACCESS, RESP} state_t;
   state_t state, state_n;

   logic [PTR_W-1:0]  rr_ptr, win, lat_w;
   logic              found;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              in_range;
   logic [DATA_W-1:0] mem [DEPTH];

   // Search starts just past the last winner, so the previous winner has lowest priority.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
   end

   assign in_range = {1'b0, lat_addr} < DEPTH_L;
   assign busy     = (state != ARB);

   always_comb begin
      state_n = state;
      case (state)
         ARB:     if (found) state_n = ACCESS;
         ACCESS:  state_n = RESP;
         RESP:    state_n = ARB;
         default: state_n = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ARB;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt        <= '0;
         resp_valid <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         rr_ptr     <= PTR_W'(NUM_REQ-1);
         lat_w      <= '0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         gnt        <= '0;
         resp_valid <= '0;
         case (state)
            ARB: if (found) begin
               lat_w     <= win;
               lat_we    <= we[win];
               lat_addr  <= addr[int'(win)*ADDR_W +: ADDR_W];
               lat_wdata <= wdata[int'(win)*DATA_W +: DATA_W];
               gnt       <= NUM_REQ'(1) << win;
               rr_ptr    <= win;
            end
            ACCESS: begin
               resp_valid <= NUM_REQ'(1) << lat_w;
               if (in_range) begin
                  rdata <= lat_we ? '0 : mem[lat_addr];
                  err   <= 1'b0;
               end else begin
                  rdata <= '0;
                  err   <= 1'b1;
               end
            end
            RESP: begin
               rdata <= '0;
               err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Storage is not reset; a reset in ACCESS suppresses the pending write.
   always_ff @(posedge clk) begin
      if (!reset && state == ACCESS && lat_we && in_range)
         mem[lat_addr] <= lat_wdata;
   end
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT pulses gnt or resp_valid.
module tb_sp_ram_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req, we, gnt, resp_valid;
   logic [15:0] addr, wdata;
   logic [7:0]  rdata;
   logic        err, busy;

   typedef struct {
      logic [1:0] id;
      logic [7:0] rd;
      logic       er;
   } resp_t;

   resp_t      resp_q[$];
   logic [1:0] gnt_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;

   sp_ram_arbiter #(.NUM_REQ(2), .DATA_W(8), .ADDR_W(8), .DEPTH(255)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .resp_valid(resp_valid), .rdata(rdata), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every pulse against the scoreboard queues.
   always @(negedge clk) begin
      if (gnt != 2'b00) begin
         if (gnt_q.size() == 0) check("unexpected_gnt", 32'(gnt), 32'h0);
         else check("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
      end
      if (resp_valid != 2'b00) begin
         if (resp_q.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'h0);
         else begin
            resp_t e;
            e = resp_q.pop_front();
            check("resp_valid", 32'(resp_valid), 32'(e.id));
            check("rdata", 32'(rdata), 32'(e.rd));
            check("err", 32'(err), 32'(e.er));
         end
      end
      if ((gnt & resp_valid) != 2'b00) check("gnt_resp_overlap", 32'(gnt & resp_valid), 32'h0);
   end

   task automatic wait_gnt(input int i);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (gnt[i]) return;
      end
      check("gnt_timeout", 32'(gnt), 32'(1 << i));
   endtask

   task automatic wait_resp(input int i);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (resp_valid[i]) return;
      end
      check("resp_timeout", 32'(resp_valid), 32'(1 << i));
   endtask

   // Single transaction by requester i; optionally changes addr once granted.
   task automatic txn(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input bit exp_err,
                      input bit chg = 1'b0, input logic [7:0] a2 = 8'h00);
      resp_t e;
      e.id = 2'(1 << i); e.rd = exp_rd; e.er = exp_err;
      gnt_q.push_back(2'(1 << i));
      resp_q.push_back(e);
      req[i] = 1'b1; we[i] = w; addr[i*8 +: 8] = a; wdata[i*8 +: 8] = d;
      wait_gnt(i);
      req[i] = 1'b0;
      if (chg) addr[i*8 +: 8] = a2;
      wait_resp(i);
   endtask

   initial begin
      resp_t e;
      reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_resp", 32'(resp_valid), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b0;

      // 1: write then read back by the other requester
      txn(0, 1, 8'h00, 8'h55, 8'h00, 0);
      txn(1, 0, 8'h00, 8'h00, 8'h55, 0);
      txn(1, 1, 8'h01, 8'h3C, 8'h00, 0);

      // 2: both requesting continuously, four reads
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         gnt_q.push_back(2'b01); e.id = 2'b01; e.rd = 8'h55; e.er = 0; resp_q.push_back(e);
         gnt_q.push_back(2'b10); e.id = 2'b10; e.rd = 8'h3C; e.er = 0; resp_q.push_back(e);
      end
      req = 2'b11; we = 2'b00; addr = {8'h01, 8'h00};
      check("rr_busy_0", 32'(busy), 0);
      for (int k = 1; k < 12; k++) begin
         @(negedge clk);
         check("rr_busy", 32'(busy), 32'(k % 3 != 0));
         if (k % 3 == 1) check("rr_gnt_slot", 32'(gnt), ((k / 3) % 2 == 0) ? 32'h1 : 32'h2);
         if (k == 10) req = 2'b00;
      end

      // 3: boundary addresses
      txn(1, 1, 8'hFE, 8'hA3, 8'h00, 0);
      txn(1, 0, 8'hFE, 8'h00, 8'hA3, 0);
      txn(0, 1, 8'hFF, 8'h77, 8'h00, 1);
      txn(0, 0, 8'hFF, 8'h00, 8'h00, 1);
      txn(0, 0, 8'hFE, 8'h00, 8'hA3, 0);

      // 4: address change after arbitration is not seen
      txn(0, 1, 8'h10, 8'h5A, 8'h00, 0);
      txn(0, 1, 8'h20, 8'h99, 8'h00, 0);
      txn(0, 0, 8'h10, 8'h00, 8'h5A, 0, 1'b1, 8'h20);
      txn(0, 0, 8'h20, 8'h00, 8'h99, 0);

      // 5: reset during ACCESS of a write
      txn(0, 1, 8'h05, 8'h11, 8'h00, 0);
      gnt_q.push_back(2'b01);
      req[0] = 1'b1; we[0] = 1'b1; addr[7:0] = 8'h05; wdata[7:0] = 8'hCC;
      wait_gnt(0);
      reset = 1'b1; req = 2'b00;
      @(negedge clk);
      check("rstacc_gnt", 32'(gnt), 0);
      check("rstacc_resp", 32'(resp_valid), 0);
      check("rstacc_busy", 32'(busy), 0);
      reset = 1'b0;
      gnt_q.push_back(2'b01); e.id = 2'b01; e.rd = 8'h11; e.er = 0; resp_q.push_back(e);
      gnt_q.push_back(2'b10); e.id = 2'b10; e.rd = 8'h3C; e.er = 0; resp_q.push_back(e);
      req = 2'b11; we = 2'b00; addr = {8'h01, 8'h05};
      wait_gnt(0);
      req[0] = 1'b0;
      wait_gnt(1);
      req[1] = 1'b0;
      wait_resp(1);

      // 6: idle
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("idle_gnt", 32'(gnt), 0);
         check("idle_resp", 32'(resp_valid), 0);
         check("idle_busy", 32'(busy), 0);
         check("idle_err", 32'(err), 0);
         check("idle_rdata", 32'(rdata), 0);
      end

      check("gnt_q_empty", 32'(gnt_q.size()), 0);
      check("resp_q_empty", 32'(resp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
